// File: rtl/contador_ctrl_pkg.sv
// Shared constants and types for the run/pause/clear counter controller.
package contador_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_LIMIT = 10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/contador_ctrl_if.sv
// Board-side bundle for the controller: push-buttons, mode switch, counter
// feedback and the control/display outputs. The master side drives the
// buttons and the counter value; the controller is the slave.
interface contador_ctrl_if #(
  parameter int BITS = 4
);
  import contador_pkg::*;

  logic                key_start_n;
  logic                key_clr_n;
  logic                key_lap_n;
  logic                sw_mode;
  logic [BITS-1:0]     cnt;
  logic                cnt_en;
  logic                cnt_clr;
  logic [BITS-1:0]     disp;
  logic                done;
  logic                wrap;
  logic [STATE_W-1:0]  state;

  modport master (
    output key_start_n, key_clr_n, key_lap_n, sw_mode, cnt,
    input  cnt_en, cnt_clr, disp, done, wrap, state
  );

  modport slave (
    input  key_start_n, key_clr_n, key_lap_n, sw_mode, cnt,
    output cnt_en, cnt_clr, disp, done, wrap, state
  );

endinterface

// File: rtl/contador_ctrl_key_sync.sv
// Two-flop synchroniser with a history flop. `level` is the synchronised
// input; `fall` flags a high-to-low transition of that level, which for an
// active-low button is a press. Flops reset to 0, so a button held low
// through reset never looks like a fresh press.
module key_sync (
  input  logic clk_buff,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic s1, s2, p;

  // Synchroniser chain plus one cycle of history for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, exactly like hardware.
  always_ff @(posedge clk_buff or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign level = s2;
  assign fall  = ~s2 & p;

endmodule

// File: rtl/contador_ctrl.sv
// Run/pause/clear controller for an enable/clear up-counter. Converts
// three active-low buttons and a mode switch into cnt_en/cnt_clr, can stop
// the counter at LIMIT, flags wraps, and offers a lap-hold display value.
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int BITS  = 4,
  parameter int LIMIT = DEF_LIMIT
) (
  input  logic            clk_buff,
  input  logic            rst,
  contador_ctrl_if.slave  bus
);

  logic start_ev, clr_ev, lap_ev, mode;
  logic start_level_unused, clr_level_unused, lap_level_unused;
  logic mode_fall_unused;

  key_sync u_sync_start (
    .clk_buff (clk_buff),
    .rst      (rst),
    .din      (bus.key_start_n),
    .level    (start_level_unused),
    .fall     (start_ev)
  );

  key_sync u_sync_clr (
    .clk_buff (clk_buff),
    .rst      (rst),
    .din      (bus.key_clr_n),
    .level    (clr_level_unused),
    .fall     (clr_ev)
  );

  key_sync u_sync_lap (
    .clk_buff (clk_buff),
    .rst      (rst),
    .din      (bus.key_lap_n),
    .level    (lap_level_unused),
    .fall     (lap_ev)
  );

  key_sync u_sync_mode (
    .clk_buff (clk_buff),
    .rst      (rst),
    .din      (bus.sw_mode),
    .level    (mode),
    .fall     (mode_fall_unused)
  );

  state_t          state_q, state_d;
  logic            clr_q, clr_d;
  logic            hold_q, hold_d;
  logic [BITS-1:0] lap_q, lap_d;
  logic            wrap_q, wrap_d;
  logic            terminal;

  // Stop mode ends the run on the edge that takes the counter to LIMIT.
  assign terminal = mode && (bus.cnt >= BITS'(LIMIT - 1));

  // Controller registers; lap_reg is a single register, so it is reset too.
  always_ff @(posedge clk_buff or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state, clear pulse, lap hold and wrap flag; clr beats terminal
  // beats start.
  // NOTE: every signal gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    hold_d  = hold_q;
    lap_d   = lap_q;
    wrap_d  = (state_q == ST_RUN) && !mode && (bus.cnt == '1);

    case (state_q)
      ST_IDLE: begin
        if (clr_ev)        clr_d   = 1'b1;
        else if (start_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (terminal) begin
          state_d = ST_DONE;
        end else if (start_ev) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clr_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (start_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clr_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Lap capture only while counting or paused; release anywhere but DONE.
    if (clr_q) begin
      hold_d = 1'b0;
    end else if (lap_ev && state_q != ST_DONE) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else if (state_q == ST_RUN || state_q == ST_PAUSE) begin
        hold_d = 1'b1;
        lap_d  = bus.cnt;
      end
    end
  end

  assign bus.cnt_en  = (state_q == ST_RUN) | clr_q;
  assign bus.cnt_clr = clr_q;
  assign bus.disp    = hold_q ? lap_q : bus.cnt;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.wrap    = wrap_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl with a behavioural model of the
// controlled enable/clear counter closing the loop on `cnt`.
module tb_contador_ctrl;

  localparam int BITS  = 4;
  localparam int LIMIT = 10;

  logic clk_buff = 1'b0;
  logic rst      = 1'b0;
  int   checks   = 0;
  int   fails    = 0;

  contador_ctrl_if #(.BITS(BITS)) bus ();

  contador_ctrl #(.BITS(BITS), .LIMIT(LIMIT)) dut (
    .clk_buff (clk_buff),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_buff = ~clk_buff;

  // The counter being controlled: clears or increments when enabled.
  always @(posedge clk_buff or negedge rst) begin
    if (!rst)             bus.cnt <= '0;
    else if (bus.cnt_en)  bus.cnt <= bus.cnt_clr ? '0 : bus.cnt + 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_buff);
    #1;
  endtask

  // Holds the selected buttons low across exactly one sampling edge.
  task automatic press(input logic s, input logic c, input logic l);
    bus.key_start_n = ~s;
    bus.key_clr_n   = ~c;
    bus.key_lap_n   = ~l;
    step(1);
    bus.key_start_n = 1'b1;
    bus.key_clr_n   = 1'b1;
    bus.key_lap_n   = 1'b1;
  endtask

  task automatic test_reset;
    step(3);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL rst_state: got %b exp 00", bus.state); end
    checks++; if (bus.cnt_en !== 1'b0) begin fails++; $display("FAIL rst_cnt_en: got %b exp 0", bus.cnt_en); end
    checks++; if (bus.cnt_clr !== 1'b0) begin fails++; $display("FAIL rst_cnt_clr: got %b exp 0", bus.cnt_clr); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b exp 0", bus.done); end
    checks++; if (bus.disp !== 4'd0) begin fails++; $display("FAIL rst_disp: got %0d exp 0", bus.disp); end
    // Start held low across reset release must not start the run.
    bus.key_start_n = 1'b0;
    rst = 1'b1;
    step(5);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL held_start_state: got %b exp 00", bus.state); end
    bus.key_start_n = 1'b1;
    step(4);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL held_release_state: got %b exp 00", bus.state); end
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL held_release_cnt: got %0d exp 0", bus.cnt); end
  endtask

  task automatic test_run_pause;
    press(1, 0, 0);          // edge N
    step(1);                 // edge N+1
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL start_latency_state: got %b exp 00", bus.state); end
    step(1);                 // edge N+2
    checks++; if (bus.state !== 2'b01) begin fails++; $display("FAIL start_state: got %b exp 01", bus.state); end
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL start_cnt: got %0d exp 0", bus.cnt); end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++; if (bus.cnt !== 4'(i)) begin fails++; $display("FAIL run_cnt_%0d: got %0d exp %0d", i, bus.cnt, i); end
    end
    press(1, 0, 0);          // cnt 4
    step(2);                 // cnt 5, then 6 with PAUSE
    checks++; if (bus.state !== 2'b10) begin fails++; $display("FAIL pause_state: got %b exp 10", bus.state); end
    checks++; if (bus.cnt_en !== 1'b0) begin fails++; $display("FAIL pause_cnt_en: got %b exp 0", bus.cnt_en); end
    checks++; if (bus.cnt !== 4'd6) begin fails++; $display("FAIL pause_cnt: got %0d exp 6", bus.cnt); end
    step(3);
    checks++; if (bus.cnt !== 4'd6) begin fails++; $display("FAIL pause_frozen: got %0d exp 6", bus.cnt); end
    press(0, 1, 0);
    step(2);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL pause_clr_state: got %b exp 00", bus.state); end
    step(1);
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL pause_clr_cnt: got %0d exp 0", bus.cnt); end
  endtask

  task automatic test_stop_mode;
    bus.sw_mode = 1'b1;
    step(3);
    press(1, 0, 0);
    step(2);                 // RUN, cnt 0
    step(9);                 // cnt 9
    checks++; if (bus.state !== 2'b01) begin fails++; $display("FAIL stop_pre_state: got %b exp 01", bus.state); end
    step(1);                 // cnt 10 with DONE
    checks++; if (bus.state !== 2'b11) begin fails++; $display("FAIL stop_state: got %b exp 11", bus.state); end
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stop_done: got %b exp 1", bus.done); end
    checks++; if (bus.cnt !== 4'd10) begin fails++; $display("FAIL stop_cnt: got %0d exp 10", bus.cnt); end
    step(3);
    checks++; if (bus.cnt !== 4'd10) begin fails++; $display("FAIL stop_hold_cnt: got %0d exp 10", bus.cnt); end
    press(1, 0, 0);
    step(3);
    checks++; if (bus.state !== 2'b11) begin fails++; $display("FAIL done_start_ignored: got %b exp 11", bus.state); end
    checks++; if (bus.cnt !== 4'd10) begin fails++; $display("FAIL done_start_cnt: got %0d exp 10", bus.cnt); end
    press(0, 1, 0);
    step(2);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL done_clr_state: got %b exp 00", bus.state); end
    checks++; if ({bus.cnt_en, bus.cnt_clr} !== 2'b11) begin fails++; $display("FAIL done_clr_pulse: got %b exp 11", {bus.cnt_en, bus.cnt_clr}); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_clr_done: got %b exp 0", bus.done); end
    step(1);
    checks++; if ({bus.cnt_en, bus.cnt_clr} !== 2'b00) begin fails++; $display("FAIL done_clr_pulse_end: got %b exp 00", {bus.cnt_en, bus.cnt_clr}); end
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL done_clr_cnt: got %0d exp 0", bus.cnt); end
  endtask

  task automatic test_wrap;
    bus.sw_mode = 1'b0;
    step(3);
    press(1, 0, 0);
    step(2);                 // RUN, cnt 0
    step(15);                // cnt 15
    checks++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL wrap_early: got %b exp 0", bus.wrap); end
    step(1);                 // cnt 0
    checks++; if (bus.wrap !== 1'b1) begin fails++; $display("FAIL wrap_pulse: got %b exp 1", bus.wrap); end
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL wrap_cnt: got %0d exp 0", bus.cnt); end
    step(1);                 // cnt 1
    checks++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL wrap_width: got %b exp 0", bus.wrap); end
    checks++; if ({bus.done, bus.state} !== 3'b001) begin fails++; $display("FAIL wrap_no_done: got %b exp 001", {bus.done, bus.state}); end
  endtask

  task automatic test_lap;
    step(2);                 // cnt 3
    press(0, 0, 1);          // cnt 4
    step(2);                 // cnt 5, then 6 with lap_reg=5
    checks++; if (bus.disp !== 4'd5) begin fails++; $display("FAIL lap_disp: got %0d exp 5", bus.disp); end
    checks++; if (bus.cnt !== 4'd6) begin fails++; $display("FAIL lap_cnt: got %0d exp 6", bus.cnt); end
    step(3);                 // cnt 9
    checks++; if (bus.disp !== 4'd5) begin fails++; $display("FAIL lap_disp_held: got %0d exp 5", bus.disp); end
    press(0, 0, 1);          // cnt 10
    step(2);                 // cnt 12, hold released
    checks++; if (bus.disp !== 4'd12) begin fails++; $display("FAIL lap_release_disp: got %0d exp 12", bus.disp); end
    step(1);
    checks++; if (bus.disp !== 4'd13) begin fails++; $display("FAIL lap_follow_disp: got %0d exp 13", bus.disp); end
    press(0, 0, 1);          // cnt 14
    step(2);                 // cnt 0, lap_reg=15
    checks++; if (bus.disp !== 4'd15) begin fails++; $display("FAIL lap2_disp: got %0d exp 15", bus.disp); end
    press(0, 1, 0);          // cnt 1
    step(2);                 // cnt 3, clear pulse, still holding
    checks++; if (bus.disp !== 4'd15) begin fails++; $display("FAIL lap_clr_pulse_disp: got %0d exp 15", bus.disp); end
    step(1);
    checks++; if (bus.disp !== 4'd0) begin fails++; $display("FAIL lap_clr_disp: got %0d exp 0", bus.disp); end
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL lap_clr_state: got %b exp 00", bus.state); end
  endtask

  task automatic test_back_to_back;
    press(1, 0, 0);
    step(2);                 // RUN, cnt 0
    step(3);                 // cnt 3
    press(1, 1, 0);          // cnt 4
    step(2);                 // cnt 6, IDLE with clear pulse
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL both_state: got %b exp 00", bus.state); end
    checks++; if ({bus.cnt_en, bus.cnt_clr} !== 2'b11) begin fails++; $display("FAIL both_pulse: got %b exp 11", {bus.cnt_en, bus.cnt_clr}); end
    checks++; if (bus.cnt !== 4'd6) begin fails++; $display("FAIL both_cnt: got %0d exp 6", bus.cnt); end
    step(1);
    checks++; if (bus.cnt !== 4'd0) begin fails++; $display("FAIL both_cleared: got %0d exp 0", bus.cnt); end
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL both_stays_idle: got %b exp 00", bus.state); end
  endtask

  task automatic test_reset_mid_run;
    press(1, 0, 0);
    step(2);                 // RUN, cnt 0
    step(4);                 // cnt 4
    press(0, 0, 1);          // cnt 5
    step(2);                 // cnt 7, lap_reg=6
    checks++; if (bus.disp !== 4'd6) begin fails++; $display("FAIL mid_lap_disp: got %0d exp 6", bus.disp); end
    step(1);
    rst = 1'b0;
    #1;
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL mid_rst_state: got %b exp 00", bus.state); end
    checks++; if ({bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap} !== 4'b0000) begin fails++; $display("FAIL mid_rst_outputs: got %b exp 0000", {bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap}); end
    checks++; if (bus.disp !== 4'd0) begin fails++; $display("FAIL mid_rst_disp: got %0d exp 0", bus.disp); end
    rst = 1'b1;
    step(3);
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL post_rst_state: got %b exp 00", bus.state); end
  endtask

  initial begin
    bus.key_start_n = 1'b1;
    bus.key_clr_n   = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.sw_mode     = 1'b0;
    test_reset();
    test_run_pause();
    test_stop_mode();
    test_wrap();
    test_lap();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
- Run/pause/clear controller for the BITS-wide enable/clear up-counter on the DE10-Lite.
- Turns three active-low push-buttons and a mode switch into the counter's `en`/`clr` controls.
- Optionally stops the counter at a terminal value, and offers a lap-hold display value.
- Runs entirely in the divided-clock domain, on the same clock as the counter it controls.

Parameters:
- BITS, 4: counter width; also the width of `cnt` and `disp`.
- LIMIT, 10: terminal count in stop mode. Legal range 1 to 2^BITS-1.

Ports:
- clk_buff  input  1  divided clock; shared with the controlled counter.
- rst  input  1  asynchronous, active-low reset.
- key_start_n  input  1  push-button, active-low; start/pause toggle.
- key_clr_n  input  1  push-button, active-low; clear.
- key_lap_n  input  1  push-button, active-low; lap hold/release.
- sw_mode  input  1  0 = free-run with wrap, 1 = stop at LIMIT.
- cnt  input  BITS  current registered counter value.
- cnt_en  output  1  counter enable.
- cnt_clr  output  1  counter synchronous clear; only meaningful while cnt_en=1.
- disp  output  BITS  value to display: lap_reg when hold=1, else cnt (combinational mux).
- done  output  1  high while in DONE.
- wrap  output  1  one-cycle pulse when the counter wraps from 2^BITS-1 to 0.
- state  output  2  FSM state, driven to LEDs.

Behaviour:
- Reset: rst=0 asynchronously forces the following, regardless of key activity or current state.
  - state=IDLE, cnt_en=0, cnt_clr=0, done=0, wrap=0, hold=0, lap_reg=0.
  - All synchroniser flops reset to 0.
- Synchronisers (keys and sw_mode):
  - Each input passes through 2 flops (s1, s2); each key also has a history flop p <= s2.
  - Press event = ~s2 & p, i.e. a falling edge of the synchronised level.
  - A key low at sampling edge N produces its event in the cycle after edge N+1; the FSM acts at edge N+2.
  - A key held through reset release gives no event until it is released and pressed again.
- States and encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Per-state event priority: clr > terminal > start. Lap is handled independently of state changes.
- IDLE:
  - start event -> RUN.
  - clr event -> stay in IDLE and issue a clear pulse.
- RUN:
  - clr event -> IDLE plus clear pulse.
  - Otherwise, if sync mode=1 and cnt >= LIMIT-1 -> DONE.
  - Otherwise, start event -> PAUSE.
- PAUSE:
  - clr event -> IDLE plus clear pulse.
  - Otherwise, start event -> RUN.
- DONE:
  - start and lap events are ignored.
  - clr event -> IDLE plus clear pulse.
- cnt_en:
  - Equals (state==RUN) | clr_q, taken from registers with no combinational path from the keys.
  - The counter therefore increments on each edge at which state==RUN.
  - In stop mode the counter reaches LIMIT on the same edge that the state becomes DONE, then holds at LIMIT.
- Clear pulse:
  - clr_q is a register set for exactly one cycle on the edge that processes the clr event.
  - While clr_q=1: cnt_en=1 and cnt_clr=1. The counter reads 0 one edge later.
  - clr_q also clears hold.
- Lap:
  - A lap event in RUN or PAUSE with hold=0 sets lap_reg <= cnt and hold <= 1.
  - A lap event with hold=1 sets hold <= 0.
  - A lap event in IDLE affects only the release case (hold=1 -> 0).
- wrap: registered, set to 1 on the edge where state==RUN and cnt == 2^BITS-1. This coincides with the counter becoming 0. Free-run mode only.
- sw_mode changing mid-RUN: takes effect 2 edges later. If cnt is already >= LIMIT, the FSM goes to DONE on the next RUN edge; the counter advances one extra count, which is accepted.
- Simultaneous clr and start events: clr wins and the state is IDLE.

Decomposition:
- contador_pkg holds:
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - DEF_LIMIT=10;
  - the 2-bit state width.
- Sub-module key_sync:
  - 2-flop synchroniser plus history flop, reset to 0, clocked by clk_buff with rst;
  - outputs `level` and `fall`;
  - instantiated 4 times (three keys and sw_mode, whose `fall` output is unused).

Test Plan:
- Reset with all keys high -> state=00, cnt_en=0, cnt_clr=0, done=0, disp=0. Keep key_start_n held low across rst release -> no transition to RUN.
- Press start (low at edge N) -> state=01 at edge N+2. Counter 0 then shows 1,2,3 on successive edges. Press start again -> PAUSE (10), cnt_en=0, counter frozen.
- sw_mode=1, LIMIT=10, run from 0 -> DONE when cnt=10, done=1, counter holds 10. Then press start -> no change. Press clr -> cnt_en=cnt_clr=1 for 1 cycle, counter 0, state IDLE.
- sw_mode=0, BITS=4, run past 15 -> wrap=1 for exactly one cycle as cnt goes 15->0; no DONE.
- In RUN at cnt=5, press lap -> disp stays 5 while cnt continues. Press lap again -> disp follows cnt. Press clr while holding -> hold cleared, disp=0.
- start and clr pressed in the same cycle during RUN -> IDLE plus clear pulse. Assert rst mid-RUN -> immediate IDLE with all outputs 0.
